cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand width of both requesters and of the shared comparator.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 (branch unit) presents an operation.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 Port: req0_op  input  1  requester 0 compare mode (0 signed, 1 unsigned).
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meanings as requester 0, for requester 1 (set/trap unit).
REQ-009 Port: rsp_valid  output  1  registered result held.
REQ-010 Port: rsp_ready  input  1  consumer takes result this cycle.
REQ-011 Port: rsp_id  output  1  requester that owns the result.
REQ-012 Port: rsp_equal, rsp_less, rsp_greater  output  1 each  registered comparator flags.

Function
REQ-013 Block SHALL share one combinational comparator between two requesters, one grant per cycle max.
REQ-014 Output register "free" SHALL mean (rsp_valid == 0) or (rsp_ready == 1).
REQ-015 When free, exactly one valid requester SHALL be granted: reqN_ready = 1 for the winner, 0 for the other.
REQ-016 When not free, req0_ready and req1_ready SHALL both be 0; no requester SHALL be granted.
REQ-017 reqN_ready SHALL never be 1 while reqN_valid is 0.
REQ-018 Arbitration SHALL be round-robin: 1-bit priority pointer names the preferred requester; on simultaneous valid the preferred one wins.
REQ-019 After any grant to requester N, pointer SHALL point to the other requester; with no grant the pointer SHALL hold.
REQ-020 A single valid requester SHALL win regardless of pointer.
REQ-021 Grant in cycle N SHALL load rsp_id and flags from the winner's operands/op, with rsp_valid = 1 in cycle N+1 (latency 1).
REQ-022 Flags SHALL follow: equal = (a == b); less/greater = signed comparison when op = 0, unsigned when op = 1; exactly one flag is 1.
REQ-023 rsp_valid with rsp_ready = 0 SHALL hold all rsp_* outputs stable.
REQ-024 rsp_ready = 1 with no new grant SHALL clear rsp_valid next cycle; with a grant, the register SHALL reload (back-to-back, throughput 1/cycle).
REQ-025 Requester operands SHALL be sampled only in the grant cycle; later changes SHALL NOT affect the held result.
REQ-026 Output register state: EMPTY (rsp_valid 0) -> FULL on grant; FULL -> EMPTY on rsp_ready without grant; FULL -> FULL on grant or stall.

Reset
REQ-027 Reset assertion SHALL immediately force rsp_valid = 0, rsp_id = 0, all flags = 0, pointer = 0 (requester 0 preferred).
REQ-028 Reset mid-operation SHALL discard any held result; no grant SHALL occur while reset is high (both readies 0).

Structure
REQ-029 Shared package cmp_pkg SHALL hold CMP_SIGNED = 0, CMP_UNSIGNED = 1, REQ_BRANCH = 0, REQ_SET = 1.
REQ-030 Comparator SHALL be a single instance of the existing cmp sub-module, its inputs muxed by the grant.
REQ-031 Arbiter, pointer and output register SHALL live in cmp_arbiter; no further sub-modules.

Verification
REQ-032 Reset release, req0 valid a=0xFFFFFFFF, b=0x00000001, op=0 -> req0_ready 1; next cycle rsp_valid 1, rsp_id 0, less 1.
REQ-033 Same operands from req1 with op=1 -> rsp_id 1, greater 1, equal 0.
REQ-034 Both valid 4 cycles, rsp_ready held 1 -> grants alternate 0,1,0,1 and rsp_valid stays 1 every cycle after the first.
REQ-035 Result held, rsp_ready 0 for 3 cycles, both valid -> both readies 0, rsp_* stable; rsp_ready 1 -> grant resumes that cycle.
REQ-036 a=b=0x12345678 -> equal 1, less 0, greater 0 in both modes.
REQ-037 Reset asserted while rsp_valid 1 -> rsp_valid 0 without a clock edge; first grant afterward goes to req0 when both valid.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants and types for the comparator arbiter
package cmp_pkg;

  localparam logic CMP_SIGNED   = 1'b0;
  localparam logic CMP_UNSIGNED = 1'b1;
  localparam logic REQ_BRANCH   = 1'b0;
  localparam logic REQ_SET      = 1'b1;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic equal;
    logic less;
    logic greater;
  } cmp_flags_t;

endpackage

// File: rtl/cmp.sv
// rtl/cmp.sv - combinational signed/unsigned magnitude comparator
module cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             equal,
  output logic             less,
  output logic             greater
);

  always_comb begin
    equal = (a == b);
    if (op == CMP_UNSIGNED) begin
      less = (a < b);
    end else begin
      less = ($signed(a) < $signed(b));
    end
    greater = !equal && !less;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one comparator between two requesters
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_equal,
  output logic             rsp_less,
  output logic             rsp_greater
);

  rsp_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  cmp_flags_t       flags_q, flags_d;
  cmp_flags_t       cmp_flags;
  logic             rsp_free;
  logic             grant0, grant1, grant_any, sel;
  logic [WIDTH-1:0] mux_a, mux_b;
  logic             mux_op;

  assign rsp_free = (state_q == RSP_EMPTY) || rsp_ready;

  // Reset gates the grant combinationally so nothing is accepted while it is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && rsp_free) begin
      if (req0_valid && req1_valid) begin
        grant0 = (ptr_q == REQ_BRANCH);
        grant1 = (ptr_q == REQ_SET);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign grant_any = grant0 || grant1;
  assign sel       = grant1 ? REQ_SET : REQ_BRANCH;
  assign mux_a     = (sel == REQ_SET) ? req1_a  : req0_a;
  assign mux_b     = (sel == REQ_SET) ? req1_b  : req0_b;
  assign mux_op    = (sel == REQ_SET) ? req1_op : req0_op;

  cmp #(.WIDTH(WIDTH)) u_cmp (
    .a       (mux_a),
    .b       (mux_b),
    .op      (mux_op),
    .equal   (cmp_flags.equal),
    .less    (cmp_flags.less),
    .greater (cmp_flags.greater)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    flags_d = flags_q;
    if (grant_any) begin
      state_d = RSP_FULL;
      ptr_d   = ~sel;
      id_d    = sel;
      flags_d = cmp_flags;
    end else if (rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RSP_EMPTY;
      ptr_q   <= REQ_BRANCH;
      id_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      flags_q <= flags_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp_valid   = (state_q == RSP_FULL);
  assign rsp_id      = id_q;
  assign rsp_equal   = flags_q.equal;
  assign rsp_less    = flags_q.less;
  assign rsp_greater = flags_q.greater;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - directed and randomized bench for cmp_arbiter
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_equal, rsp_less, rsp_greater;

  int vectors = 0;
  int miscompares = 0;

  logic m_ptr, m_valid, m_id, m_eq, m_lt, m_gt;

  cmp_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_equal(rsp_equal), .rsp_less(rsp_less), .rsp_greater(rsp_greater)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  function automatic longint sval(input logic [31:0] x);
    return x[31] ? (longint'(x) - 64'sh1_0000_0000) : longint'(x);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_eq = 0; m_lt = 0; m_gt = 0;
  endtask

  function automatic int model_grant();
    if (reset || (m_valid && !rsp_ready)) return -1;
    if (req0_valid && req1_valid) return int'(m_ptr);
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic [31:0] a, b;
    logic op;
    if (g >= 0) begin
      a  = (g == 1) ? req1_a  : req0_a;
      b  = (g == 1) ? req1_b  : req0_b;
      op = (g == 1) ? req1_op : req0_op;
      m_eq = (a == b);
      if (op) begin
        m_lt = longint'(a) < longint'(b);
        m_gt = longint'(a) > longint'(b);
      end else begin
        m_lt = sval(a) < sval(b);
        m_gt = sval(a) > sval(b);
      end
      m_valid = 1;
      m_id    = (g == 1);
      m_ptr   = (g == 0);
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [7:0] rsp_obs();
    return {3'b0, rsp_valid, rsp_id, rsp_equal, rsp_less, rsp_greater};
  endfunction

  function automatic logic [7:0] rsp_exp();
    return {3'b0, m_valid, m_id, m_eq, m_lt, m_gt};
  endfunction

  // Inputs are applied 1ns after a rising edge; readies are checked at the falling edge.
  task automatic step(input string tag);
    int g;
    logic [1:0] er;
    @(negedge clk);
    g  = model_grant();
    er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk({tag, "/ready"}, {6'b0, req1_ready, req0_ready}, {6'b0, er});
    @(posedge clk);
    model_update(g);
    #1;
    chk({tag, "/rsp"}, rsp_obs(), rsp_exp());
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic o0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic o1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready  = rr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 32'h5, 32'h6, 0, 1, 32'h7, 32'h7, 1, 1);
    model_reset();
    #1;
    chk("reset_state", rsp_obs(), 8'h00);
    chk("reset_ready", {6'b0, req1_ready, req0_ready}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle");

    drive(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 1);
    step("req0_signed");
    chk("req0_signed_less", {7'b0, rsp_less}, 8'h01);

    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 1, 1);
    step("req1_unsigned");
    chk("req1_unsigned_flags", {4'b0, rsp_id, rsp_equal, rsp_less, rsp_greater}, 8'h09);

    drive(1, 32'h10, 32'h20, 0, 1, 32'h30, 32'h20, 1, 1);
    for (int i = 0; i < 4; i++) step("both_valid_rr");

    drive(1, 32'h1, 32'h2, 1, 1, 32'h3, 32'h2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      req0_a = $urandom; req1_b = $urandom;
    end
    rsp_ready = 1;
    step("stall_release");

    drive(1, 32'h1234_5678, 32'h1234_5678, 0, 0, 0, 0, 0, 1);
    step("equal_signed");
    chk("equal_signed_flags", {5'b0, rsp_equal, rsp_less, rsp_greater}, 8'h04);
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 32'h1234_5678, 1, 1);
    step("equal_unsigned");

    drive(1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0);
    step("pre_reset");
    reset = 1'b1;
    #2;
    model_reset();
    chk("async_reset_rsp", rsp_obs(), 8'h00);
    chk("async_reset_ready", {6'b0, req1_ready, req0_ready}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1;
    step("post_reset_grant");
    chk("post_reset_id", {7'b0, rsp_id}, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] base;
      base = $urandom;
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_op    = $urandom_range(0, 1);
      req1_op    = $urandom_range(0, 1);
      req0_a     = base;
      req0_b     = ($urandom_range(0, 3) == 0) ? base : base + $urandom_range(0, 8) - 4;
      req1_a     = $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
